// File: rtl/signal_sequencer.sv
// Round-robin grant sequencer: each grant runs GREEN -> YELLOW -> ALLRED,
// with phase lengths set by parameters and timed by one shared down-counter.
module signal_sequencer #(
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 2,
   parameter int RED_CYC    = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       L,
   input  logic       T,
   input  logic       P,
   output logic       GL,
   output logic       GT,
   output logic       GP,
   output logic       Y,
   output logic       R,
   output logic [1:0] OWN,
   output logic       BUSY,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2,
      ST_ALLRED = 2'd3
   } state_t;

   localparam logic [7:0] G_LOAD = 8'(GREEN_CYC - 1);
   localparam logic [7:0] Y_LOAD = 8'(YELLOW_CYC - 1);
   localparam logic [7:0] R_LOAD = 8'(RED_CYC - 1);

   state_t     r_state, w_state_n;
   logic [7:0] r_cnt, w_cnt_n;
   logic [1:0] r_ptr, w_ptr_n;
   logic [1:0] w_win;
   logic       w_any;
   logic       w_gl, w_gt, w_gp, w_y, w_r, w_busy;
   logic [1:0] w_own;

   assign w_any       = L | T | P;
   assign o_dbg_state = r_state;

   // Search order starts just after the last owner (1=L, 2=T, 3=P).
   always_comb begin
      w_win = 2'd0;
      case (r_ptr)
         2'd1: begin
            if (T)      w_win = 2'd2;
            else if (P) w_win = 2'd3;
            else if (L) w_win = 2'd1;
         end
         2'd2: begin
            if (P)      w_win = 2'd3;
            else if (L) w_win = 2'd1;
            else if (T) w_win = 2'd2;
         end
         default: begin
            if (L)      w_win = 2'd1;
            else if (T) w_win = 2'd2;
            else if (P) w_win = 2'd3;
         end
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_ptr_n   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            w_cnt_n = 8'd0;
            if (w_any) begin
               w_state_n = ST_GREEN;
               w_cnt_n   = G_LOAD;
               w_ptr_n   = w_win;
            end
         end
         ST_GREEN: begin
            if (r_cnt == 8'd0) begin
               w_state_n = ST_YELLOW;
               w_cnt_n   = Y_LOAD;
            end else begin
               w_cnt_n = r_cnt - 8'd1;
            end
         end
         ST_YELLOW: begin
            if (r_cnt == 8'd0) begin
               w_state_n = ST_ALLRED;
               w_cnt_n   = R_LOAD;
            end else begin
               w_cnt_n = r_cnt - 8'd1;
            end
         end
         ST_ALLRED: begin
            if (r_cnt == 8'd0) begin
               if (w_any) begin
                  w_state_n = ST_GREEN;
                  w_cnt_n   = G_LOAD;
                  w_ptr_n   = w_win;
               end else begin
                  w_state_n = ST_IDLE;
                  w_cnt_n   = 8'd0;
               end
            end else begin
               w_cnt_n = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_cnt_n   = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with it.
   always_comb begin
      w_gl   = (w_state_n == ST_GREEN) && (w_ptr_n == 2'd1);
      w_gt   = (w_state_n == ST_GREEN) && (w_ptr_n == 2'd2);
      w_gp   = (w_state_n == ST_GREEN) && (w_ptr_n == 2'd3);
      w_y    = (w_state_n == ST_YELLOW);
      w_r    = (w_state_n == ST_IDLE) || (w_state_n == ST_ALLRED);
      w_own  = ((w_state_n == ST_GREEN) || (w_state_n == ST_YELLOW)) ? w_ptr_n : 2'd0;
      w_busy = (w_state_n != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
         r_ptr   <= 2'd3;
         GL      <= 1'b0;
         GT      <= 1'b0;
         GP      <= 1'b0;
         Y       <= 1'b0;
         R       <= 1'b1;
         OWN     <= 2'd0;
         BUSY    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_ptr   <= w_ptr_n;
         GL      <= w_gl;
         GT      <= w_gt;
         GP      <= w_gp;
         Y       <= w_y;
         R       <= w_r;
         OWN     <= w_own;
         BUSY    <= w_busy;
      end
   end

endmodule

// File: tb/tb_signal_sequencer.sv
// Directed bench for signal_sequencer: default 8/2/1 instance plus a 1/1/1 corner instance.
module tb_signal_sequencer;

   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic       L = 1'b0, T = 1'b0, P = 1'b0;
   logic       GL, GT, GP, Y, R, BUSY;
   logic [1:0] OWN, dbg_state;
   logic       Lc = 1'b0, Tc = 1'b0, Pc = 1'b0;
   logic       GLc, GTc, GPc, Yc, Rc, BUSYc;
   logic [1:0] OWNc, dbg_state_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   signal_sequencer dut (
      .CLK(clk), .RST(RST), .L(L), .T(T), .P(P),
      .GL(GL), .GT(GT), .GP(GP), .Y(Y), .R(R), .OWN(OWN), .BUSY(BUSY),
      .o_dbg_state(dbg_state)
   );

   signal_sequencer #(.GREEN_CYC(1), .YELLOW_CYC(1), .RED_CYC(1)) dut_c (
      .CLK(clk), .RST(RST), .L(Lc), .T(Tc), .P(Pc),
      .GL(GLc), .GT(GTc), .GP(GPc), .Y(Yc), .R(Rc), .OWN(OWNc), .BUSY(BUSYc),
      .o_dbg_state(dbg_state_c)
   );

   // Output vector {GL,GT,GP,Y,R,OWN,BUSY}
   function automatic logic [7:0] obs_vec();
      return {GL, GT, GP, Y, R, OWN, BUSY};
   endfunction

   function automatic logic [7:0] obs_vec_c();
      return {GLc, GTc, GPc, Yc, Rc, OWNc, BUSYc};
   endfunction

   // ph: 0 idle, 1 green, 2 yellow, 3 allred; own: 1=L 2=T 3=P
   function automatic logic [7:0] exp_vec(input int ph, input int own);
      logic [1:0] o;
      o = 2'(own);
      case (ph)
         1:       return {o == 2'd1, o == 2'd2, o == 2'd3, 1'b0, 1'b0, o, 1'b1};
         2:       return {3'b000, 1'b1, 1'b0, o, 1'b1};
         3:       return {3'b000, 1'b0, 1'b1, 2'd0, 1'b1};
         default: return {3'b000, 1'b0, 1'b1, 2'd0, 1'b0};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Leaves RST low at a falling edge; the next rising edge is edge 0.
   task automatic do_reset(input string tag);
      @(negedge clk);
      RST = 1'b1;
      L = 1'b0; T = 1'b0; P = 1'b0; Lc = 1'b0;
      repeat (2) @(negedge clk);
      check_eq({tag, "_rst_out"}, 32'(obs_vec()), 32'(exp_vec(0, 0)));
      check_eq({tag, "_rst_state"}, 32'(dbg_state), 32'd0);
      RST = 1'b0;
   endtask

   initial begin
      // Single request held: green 1-8, yellow 9-10, red 11, green again 12
      do_reset("single");
      L = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         int ph;
         @(negedge clk);
         ph = (c <= 8 || c == 12) ? 1 : (c <= 10 ? 2 : 3);
         check_eq($sformatf("single_c%0d", c), 32'(obs_vec()), 32'(exp_vec(ph, 1)));
      end

      // All three requesting: L, T, P, L with 11-cycle spacing
      do_reset("rr");
      L = 1'b1; T = 1'b1; P = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         int k, ph, own;
         @(negedge clk);
         k   = (c - 1) % 11;
         ph  = (k < 8) ? 1 : (k < 10 ? 2 : 3);
         own = ((c - 1) / 11) % 3 + 1;
         check_eq($sformatf("rr_c%0d", c), 32'(obs_vec()), 32'(exp_vec(ph, own)));
      end

      // T for one cycle only: full phase sequence then IDLE
      do_reset("drop");
      T = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         int ph;
         @(negedge clk);
         T = 1'b0;
         ph = (c <= 8) ? 1 : (c <= 10 ? 2 : (c == 11 ? 3 : 0));
         check_eq($sformatf("drop_c%0d", c), 32'(obs_vec()), 32'(exp_vec(ph, 2)));
      end
      check_eq("drop_state_idle", 32'(dbg_state), 32'd0);

      // Reset pulsed in cycle 4 of GL acts without a clock edge
      do_reset("midrst");
      L = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check_eq($sformatf("midrst_c%0d", c), 32'(obs_vec()), 32'(exp_vec(1, 1)));
      end
      #2 RST = 1'b1;
      #1;
      check_eq("midrst_async_out", 32'(obs_vec()), 32'(exp_vec(0, 0)));
      check_eq("midrst_async_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      RST = 1'b0;
      L = 1'b1; T = 1'b1;
      @(negedge clk);
      check_eq("midrst_l_first", 32'(obs_vec()), 32'(exp_vec(1, 1)));

      // Last owner L, then only P: GP right after ALLRED with no IDLE
      do_reset("skip");
      L = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         int ph, own;
         @(negedge clk);
         L = 1'b0; P = 1'b1;
         ph  = (c <= 8 || c == 12) ? 1 : (c <= 10 ? 2 : 3);
         own = (c == 12) ? 3 : 1;
         check_eq($sformatf("skip_c%0d", c), 32'(obs_vec()), 32'(exp_vec(ph, own)));
      end

      // 1/1/1 corner instance: GL, Y, R repeating with period 3
      do_reset("corner");
      Lc = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         int k;
         @(negedge clk);
         k = (c - 1) % 3;
         check_eq($sformatf("corner_c%0d", c), 32'(obs_vec_c()), 32'(exp_vec(k + 1, 1)));
      end
      check_eq("corner_state_allred", 32'(dbg_state_c), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/signal_sequencer.md
SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

Interface
REQ-001 Parameter GREEN_CYC, default 8, gives the grant (green) phase length in cycles; legal range is 1..255.
REQ-002 Parameter YELLOW_CYC, default 2, gives the clearance (yellow) phase length in cycles; legal range is 1..255.
REQ-003 Parameter RED_CYC, default 1, gives the all-red phase length in cycles; legal range is 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous active-high reset.
REQ-005 L  in  1  level-sensitive request from requester L.
REQ-006 T  in  1  level-sensitive request from requester T.
REQ-007 P  in  1  level-sensitive request from requester P.
REQ-008 GL, GT, GP  out  1 each  grant to L, T and P; at most one is high in any cycle.
REQ-009 Y  out  1  clearance phase is active.
REQ-010 R  out  1  all-red (no owner) is active.
REQ-011 OWN  out  2  current owner: 0 = none, 1 = L, 2 = T, 3 = P.
REQ-012 BUSY  out  1  high in every state except IDLE.

Function
REQ-013 All outputs SHALL be registered; requests SHALL be sampled only on CLK rising edges.
REQ-014 The FSM SHALL have exactly four states: IDLE, GREEN, YELLOW and ALLRED.
REQ-015 IDLE: R=1, OWN=0, all grants and Y at 0.
- If any request is sampled high, go to GREEN of the arbitration winner on the next edge.
- Otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin in the order L->T->P->L, starting after the last granted requester; requesters whose input is low are skipped.
REQ-017 GREEN SHALL last exactly GREEN_CYC cycles.
- The winner's grant is high and OWN holds the winner's code.
- Y=0, R=0.
- Dropping the request SHALL NOT shorten the phase.
REQ-018 YELLOW SHALL last exactly YELLOW_CYC cycles.
- Y=1, all grants low, OWN unchanged, R=0.
REQ-019 ALLRED SHALL last exactly RED_CYC cycles.
- R=1, OWN=0, grants and Y low.
REQ-020 On the last ALLRED cycle, requests SHALL be sampled.
- If any request is high, go directly to GREEN of the next round-robin winner.
- Otherwise go to IDLE.
REQ-021 Phase timing SHALL use one 8-bit down-counter.
- On phase entry, load the phase length minus 1.
- Leave the phase on the edge where the counter equals 0.
- The counter SHALL never wrap.
REQ-022 The round-robin pointer SHALL update only on entry to GREEN, and SHALL record the new owner.
REQ-023 If the only pending requester is the last owner, it SHALL be granted again after ALLRED.
REQ-024 Simultaneous requests SHALL be resolved only by the round-robin order; there SHALL be no fixed priority apart from the post-reset pointer.
REQ-025 Request latency SHALL be exactly one cycle from the sampling edge in IDLE to the grant appearing.

Reset
REQ-026 While RST=1, the block SHALL immediately, without waiting for CLK:
- be in state IDLE;
- drive R=1, OWN=0, BUSY=0, and grants and Y at 0;
- clear the counter to 0;
- set the pointer to P, so that L wins the first arbitration.
REQ-027 Assertion of RST in any state, including mid-GREEN, SHALL abort the phase with no YELLOW or ALLRED sequence.
REQ-028 After RST deasserts, the first rising edge SHALL evaluate the requests as in IDLE.

Verification (defaults 8/2/1; edge 0 is the first sampling edge after reset)
REQ-029 Single request:
- Stimulus: L=1 held from edge 0.
- Response: GL=1 and OWN=1 in cycles 1-8, Y=1 in cycles 9-10, R=1 in cycle 11, GL=1 again in cycle 12.
REQ-030 Round-robin:
- Stimulus: L=T=P=1 held.
- Response: grant order L, T, P, L with 11-cycle spacing; never two grants high together.
REQ-031 Request drop:
- Stimulus: T=1 for 1 cycle only, from IDLE.
- Response: GT=1 for a full 8 cycles, then YELLOW, then ALLRED, then IDLE with BUSY=0.
REQ-032 Mid-green reset:
- Stimulus: RST pulsed high in cycle 4 of GL.
- Response: outputs go to R=1, OWN=0 asynchronously; with L=T=1 afterwards, L wins first.
REQ-033 Skip idle requester:
- Stimulus: last owner L, then only P=1.
- Response: GP=1 directly after ALLRED, with no IDLE cycle.
REQ-034 Parameter corner:
- Stimulus: GREEN_CYC=YELLOW_CYC=RED_CYC=1 and L=1 held.
- Response: a 3-cycle period of GL, Y, R repeating.
